led_pattern_driver: RTL and testbench

Consumes the slow square wave produced by the 20-bit frequency divider (its MSB, ~2 Hz from the 2.08 MHz internal oscillator) and drives the active-low on-board LED. It synchronises the divided signal into the oscillator domain and turns each rising edge into a one-cycle tick. The ticks step a 16-entry blink pattern or a toggle state, and the result is gated by a PWM brightness control. It replaces the ad-hoc toggle flops at the top level and runs on the same oscillator clock as the divider.

---
 rtl/led_pattern_driver_pkg.sv | 15 +
 rtl/led_pattern_driver_rate_edge_sync.sv | 34 +++
 rtl/led_pattern_driver.sv | 86 ++++++++
 tb/tb_led_pattern_driver.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_pattern_driver_pkg.sv
// Shared constants for the LED pattern driver: mode encodings and defaults.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_TOGGLE  = 2'd1,
    MODE_PATTERN = 2'd2,
    MODE_ON      = 2'd3
  } mode_e;

  localparam int          PWM_BITS_DEF = 4;
  // Heartbeat: two short blinks at the start of each 16-step frame.
  localparam logic [15:0] PATTERN_DEF  = 16'h0005;

endpackage

// File: rtl/led_pattern_driver_rate_edge_sync.sv
// Turns an asynchronous slow square wave into a one-cycle strobe per rising
// edge. Holdoff keeps a level that is already high at reset from being
// mistaken for an edge.
module rate_edge_sync (
  input  logic CLOCK,
  input  logic RESET,
  input  logic RATE_IN,
  output logic TICK
);

  logic       s1_q, s2_q, s2d_q;
  logic [1:0] hold_q;
  logic       tick_q;

  // 2-flop synchroniser, edge detect on the synchronised level, holdoff gate
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s2d_q  <= 1'b0;
      hold_q <= 2'd0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= RATE_IN;
      s2_q   <= s1_q;
      s2d_q  <= s2_q;
      if (hold_q != 2'd3) hold_q <= hold_q + 2'd1;
      tick_q <= s2_q & ~s2d_q & (hold_q == 2'd3);
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/led_pattern_driver.sv
// Drives the active-low LED from the divided rate signal: steps a blink
// pattern or toggle state on each tick, then gates the result with PWM.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter logic [15:0] PATTERN  = PATTERN_DEF,
  parameter int          PWM_BITS = PWM_BITS_DEF
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                RATE_IN,
  input  logic [1:0]          MODE,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic                TICK,
  output logic [3:0]          STEP,
  output logic                LEDn
);

  logic                tick;
  mode_e               mode_in;
  mode_e               mode_q;
  logic [3:0]          step_q, step_d;
  logic                tog_q, tog_d;
  logic [PWM_BITS-1:0] cnt_q;
  logic                led_n_q;
  logic                lit;
  logic                pwm_on;

  rate_edge_sync u_sync (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .RATE_IN (RATE_IN),
    .TICK    (tick)
  );

  assign mode_in = mode_e'(MODE);

  // Next step/toggle: a mode change restarts the sequence and swallows a
  // coincident tick so the new mode always begins at step 0.
  always_comb begin
    step_d = step_q;
    tog_d  = tog_q;
    if (mode_in != mode_q) begin
      step_d = 4'd0;
      tog_d  = 1'b0;
    end else if (tick) begin
      step_d = step_q + 4'd1;
      if (mode_q == MODE_TOGGLE) tog_d = ~tog_q;
    end
  end

  // Lit value per mode from registered state; PWM compare on free counter
  always_comb begin
    lit = 1'b0;
    case (mode_q)
      MODE_OFF:     lit = 1'b0;
      MODE_TOGGLE:  lit = tog_q;
      MODE_PATTERN: lit = PATTERN[step_q];
      MODE_ON:      lit = 1'b1;
      default:      lit = 1'b0;
    endcase
    pwm_on = (&BRIGHT) | (cnt_q < BRIGHT);
  end

  // State registers; LEDn is registered so it lags step/toggle by a cycle
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mode_q  <= mode_in;
      step_q  <= 4'd0;
      tog_q   <= 1'b0;
      cnt_q   <= '0;
      led_n_q <= 1'b1;
    end else begin
      mode_q  <= mode_in;
      step_q  <= step_d;
      tog_q   <= tog_d;
      cnt_q   <= cnt_q + PWM_BITS'(1);
      led_n_q <= ~(lit & pwm_on);
    end
  end

  assign TICK = tick;
  assign STEP = step_q;
  assign LEDn = led_n_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench: expected STEP after each tick is queued when RATE_IN is
// raised and checked by a monitor when the tick appears.
module tb_led_pattern_driver;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       RATE_IN = 1'b0;
  logic [1:0] MODE = 2'd1;
  logic [3:0] BRIGHT = 4'hF;
  logic       TICK;
  logic [3:0] STEP;
  logic       LEDn;

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0] exp_q[$];
  bit         pend = 1'b0;
  logic [3:0] pend_exp;

  led_pattern_driver #(.PATTERN(16'h0005), .PWM_BITS(4)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .RATE_IN (RATE_IN),
    .MODE    (MODE),
    .BRIGHT  (BRIGHT),
    .TICK    (TICK),
    .STEP    (STEP),
    .LEDn    (LEDn)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: each tick pops the STEP expected one cycle later
  always @(negedge CLOCK) begin
    if (pend) begin
      chk("sb_step", 32'(STEP), 32'(pend_exp));
      pend = 1'b0;
    end
    if (TICK === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        pend_exp = exp_q.pop_front();
        pend = 1'b1;
      end
    end
  end

  // One RATE_IN period; optionally change MODE on the cycle TICK is high
  task automatic rate_pulse(input logic [3:0] exp_step, input bit sw, input logic [1:0] nm);
    int nt;
    exp_q.push_back(exp_step);
    nt = 0;
    RATE_IN = 1'b1;
    repeat (10) begin
      @(negedge CLOCK);
      if (TICK === 1'b1) begin
        nt++;
        if (sw) MODE = nm;
      end
    end
    RATE_IN = 1'b0;
    repeat (4) @(negedge CLOCK);
    chk("tick_count", 32'(nt), 1);
    if (nt == 0 && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
  endtask

  initial begin
    int lows;
    int nt;

    // Reset, then exact synchroniser latency in toggle mode
    RESET = 1'b1; MODE = 2'd1; BRIGHT = 4'hF; RATE_IN = 1'b0;
    repeat (4) @(negedge CLOCK);
    chk("rst_tick", 32'(TICK), 0);
    chk("rst_step", 32'(STEP), 0);
    chk("rst_led",  32'(LEDn), 1);
    RESET = 1'b0;
    repeat (5) @(negedge CLOCK);
    exp_q.push_back(4'd1);
    RATE_IN = 1'b1;
    @(negedge CLOCK); chk("lat_k",  32'(TICK), 0);
    @(negedge CLOCK); chk("lat_k1", 32'(TICK), 0);
    @(negedge CLOCK); chk("lat_k2", 32'(TICK), 1); chk("lat_step0", 32'(STEP), 0);
    @(negedge CLOCK); chk("lat_k3", 32'(TICK), 0); chk("lat_step1", 32'(STEP), 1);
    chk("lat_led_lag", 32'(LEDn), 1);
    @(negedge CLOCK); chk("lat_led_on", 32'(LEDn), 0);
    RATE_IN = 1'b0;
    repeat (4) @(negedge CLOCK);
    rate_pulse(4'd2, 1'b0, 2'd0);
    chk("toggle_off", 32'(LEDn), 1);

    // Pattern mode, 20 ticks including the 15->0 wrap
    MODE = 2'd2;
    repeat (2) @(negedge CLOCK);
    chk("pat_restart", 32'(STEP), 0);
    chk("pat_led0", 32'(LEDn), 0);
    for (int i = 1; i <= 20; i++) begin
      rate_pulse(4'(i % 16), 1'b0, 2'd0);
      chk("pat_led", 32'(LEDn), ((i % 16) == 0 || (i % 16) == 2) ? 0 : 1);
    end

    // PWM duty in steady-on mode
    MODE = 2'd3; BRIGHT = 4'd0;
    repeat (2) @(negedge CLOCK);
    lows = 0;
    repeat (64) begin @(negedge CLOCK); if (LEDn === 1'b0) lows++; end
    chk("pwm_b0", 32'(lows), 0);
    BRIGHT = 4'd4;
    lows = 0;
    repeat (64) begin @(negedge CLOCK); if (LEDn === 1'b0) lows++; end
    chk("pwm_b4", 32'(lows), 16);
    BRIGHT = 4'hF;
    lows = 0;
    repeat (64) begin @(negedge CLOCK); if (LEDn === 1'b0) lows++; end
    chk("pwm_bF", 32'(lows), 64);

    // Mode change on the tick edge wins over the advance
    MODE = 2'd2;
    repeat (2) @(negedge CLOCK);
    rate_pulse(4'd1, 1'b0, 2'd0);
    rate_pulse(4'd2, 1'b0, 2'd0);
    rate_pulse(4'd0, 1'b1, 2'd1);
    chk("mc_step", 32'(STEP), 0);
    chk("mc_tog0", 32'(LEDn), 1);
    rate_pulse(4'd1, 1'b0, 2'd0);
    chk("mc_tog1", 32'(LEDn), 0);

    // RATE_IN held high through reset produces no tick
    RESET = 1'b1; RATE_IN = 1'b1;
    repeat (4) @(negedge CLOCK);
    RESET = 1'b0;
    nt = 0;
    repeat (100) begin @(negedge CLOCK); if (TICK === 1'b1) nt++; end
    chk("hold_no_tick", 32'(nt), 0);
    chk("hold_step", 32'(STEP), 0);
    chk("hold_led", 32'(LEDn), 1);
    RATE_IN = 1'b0;
    repeat (4) @(negedge CLOCK);
    rate_pulse(4'd1, 1'b0, 2'd0);
    chk("hold_after_led", 32'(LEDn), 0);

    // Reset at STEP=7 with an edge still in the synchroniser
    MODE = 2'd2;
    repeat (2) @(negedge CLOCK);
    for (int i = 1; i <= 7; i++) rate_pulse(4'(i), 1'b0, 2'd0);
    chk("mid_step7", 32'(STEP), 7);
    RATE_IN = 1'b1;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    chk("mid_step", 32'(STEP), 0);
    chk("mid_tick", 32'(TICK), 0);
    chk("mid_led",  32'(LEDn), 1);
    RATE_IN = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b0;
    nt = 0;
    repeat (10) begin @(negedge CLOCK); if (TICK === 1'b1) nt++; end
    chk("mid_dropped", 32'(nt), 0);
    rate_pulse(4'd1, 1'b0, 2'd0);
    chk("mid_after_led", 32'(LEDn), 1);

    repeat (2) @(negedge CLOCK);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
